uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have port clk, input, 1, system clock; all logic on rising edge.
REQ-002 SHALL have port rstb, input, 1, reset, synchronous and active-high (asserted 1 clears the block on the next clk edge).
REQ-003 SHALL have port bclkx8, input, 1, level clock at 8x baud rate; one tick = a clk cycle where bclkx8=1 and its previous-cycle registered value=0.
REQ-004 SHALL have port rxd, input, 1, asynchronous serial line, idle high, 8N1, LSB first.
REQ-005 SHALL have port clrrdrf, input, 1, one-clk read strobe from host; clears rdrf and oe.
REQ-006 SHALL have port rdr, output, 8, receive data register.
REQ-007 SHALL have port rdrf, output, 1, receive data register full.
REQ-008 SHALL have port oe, output, 1, overrun error flag.
REQ-009 SHALL have port fe, output, 1, framing error of the frame held in rdr.

Function
REQ-010 SHALL pass rxd through a two-flop synchronizer; all rxd references below mean the synchronized value (2 clk latency).
REQ-011 SHALL implement states IDLE, START_DET, RDATA, STOP; unused encodings SHALL go to IDLE.
REQ-012 SHALL hold a 3-bit tick counter (ct1) and a 4-bit bit counter (ct2), cleared on every state entry from IDLE.
REQ-013 IDLE: on a tick with rxd=0 -> START_DET, ct1=0; otherwise remain.
REQ-014 START_DET: on the 4th tick after entry, rxd=0 -> RDATA with ct1=0 and ct2=0; rxd=1 -> IDLE (glitch rejected, no flag change).
REQ-015 RDATA: on every 8th tick sample rxd and shift it into the MSB of the 8-bit rsr (right shift); increment ct2; after the 8th data sample -> STOP.
REQ-016 STOP: on the 8th tick, sample rxd as the stop bit, then -> IDLE in the same cycle.
REQ-017 At STOP completion with rdrf=0 or clrrdrf=1: rdr<=rsr, rdrf<=1, fe<=(stop bit==0), oe unchanged except as in REQ-019.
REQ-018 At STOP completion with rdrf=1 and clrrdrf=0: rdr and fe unchanged, oe<=1, new frame discarded.
REQ-019 clrrdrf=1 alone SHALL clear rdrf and oe on the next edge; simultaneous with a frame load, rdrf ends 1 and oe ends 0.
REQ-020 rdrf, rdr and fe SHALL update one clk after the tick cycle completing STOP.
REQ-021 A frame with fe=1 SHALL still load rdr and set rdrf; the receiver SHALL NOT wait for line high before re-arming (next tick with rxd=0 starts a new frame).
REQ-022 Ticks SHALL be the only time base; with bclkx8 stuck, state, counters and flags SHALL hold.

Reset
REQ-023 rstb=1 SHALL force state=IDLE, ct1=0, ct2=0, rsr=0, rdr=8'h00, rdrf=0, oe=0, fe=0, synchronizer flops=1, edge-detect flop=0, overriding all other inputs including clrrdrf.
REQ-024 Reset mid-frame SHALL abandon the frame without flag updates; reception restarts on the next falling edge after release.

Configuration
REQ-025 Macro UART_RX_MAJORITY_EN defined: each start-check, data and stop decision SHALL be the 2-of-3 majority of rxd at ticks N-2, N-1, N of that window (N=4 for start, 8 otherwise).
REQ-026 Macro UART_RX_MAJORITY_EN undefined: each decision SHALL use the single rxd sample at tick N; timing of state transitions SHALL be identical in both builds.

Verification
REQ-027 Frame 0x55, valid stop, rdrf=0 -> rdr=8'h55, rdrf=1, fe=0, oe=0 one clk after the final STOP tick.
REQ-028 Frame 0xA3 with stop bit 0 -> rdr=8'hA3, rdrf=1, fe=1.
REQ-029 Frames 0x11 then 0x22 with no clrrdrf -> rdr=8'h11, oe=1; then clrrdrf pulse -> rdrf=0, oe=0.
REQ-030 rxd low for 2 ticks only from IDLE -> return to IDLE, rdrf stays 0, next frame 0x7E received correctly.
REQ-031 clrrdrf asserted in the same cycle as frame 0xC4 load while rdrf=1 -> rdr=8'hC4, rdrf=1, oe=0.
REQ-032 rstb=1 during bit 4 of frame 0xFF -> all outputs 0 next edge; subsequent frame 0x0F yields rdr=8'h0F; with UART_RX_MAJORITY_EN, a 1-clk glitch at tick 8 of bit 0 of frame 0x0F does not alter rdr.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver timed by an 8x baud tick, with overrun and framing flags.
// Optional build macro UART_RX_MAJORITY_EN: bit decisions become a 2-of-3 vote over the last three ticks.
module uart_rx (
  input  logic       clk,
  input  logic       rstb,
  input  logic       bclkx8,
  input  logic       rxd,
  input  logic       clrrdrf,
  output logic [7:0] rdr,
  output logic       rdrf,
  output logic       oe,
  output logic       fe
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START_DET = 2'd1,
    RDATA     = 2'd2,
    STOP      = 2'd3
  } state_t;

  state_t     state;
  logic       rxs1;
  logic       rxs2;
  logic       bclkd;
  logic       tick;
  logic       bitval;
  logic       load;
  logic [2:0] ct1;
  logic [3:0] ct2;
  logic [7:0] rsr;

  always_ff @(posedge clk) begin
    if (rstb) begin
      rxs1  <= 1'b1;
      rxs2  <= 1'b1;
      bclkd <= 1'b0;
    end else begin
      rxs1  <= rxd;
      rxs2  <= rxs1;
      bclkd <= bclkx8;
    end
  end

  assign tick = bclkx8 & ~bclkd;

`ifdef UART_RX_MAJORITY_EN
  // hist[1] is the line at tick N-2 and hist[0] at tick N-1 when tick N arrives.
  logic [1:0] hist;

  always_ff @(posedge clk) begin
    if (rstb) begin
      hist <= 2'b11;
    end else if (tick) begin
      hist <= {hist[0], rxs2};
    end
  end

  assign bitval = (hist[1] & hist[0]) | (hist[1] & rxs2) | (hist[0] & rxs2);
`else
  assign bitval = rxs2;
`endif

  assign load = tick && (state == STOP) && (ct1 == 3'd7);

  always_ff @(posedge clk) begin
    if (rstb) begin
      state <= IDLE;
      ct1   <= 3'd0;
      ct2   <= 4'd0;
      rsr   <= 8'h00;
      rdr   <= 8'h00;
      rdrf  <= 1'b0;
      oe    <= 1'b0;
      fe    <= 1'b0;
    end else begin
      if (tick) begin
        case (state)
          IDLE: begin
            if (!rxs2) begin
              state <= START_DET;
              ct1   <= 3'd0;
              ct2   <= 4'd0;
            end
          end
          START_DET: begin
            ct1 <= ct1 + 3'd1;
            if (ct1 == 3'd3) begin
              ct1   <= 3'd0;
              ct2   <= 4'd0;
              state <= bitval ? IDLE : RDATA;
            end
          end
          RDATA: begin
            // ct1 wraps to zero on the 8th tick, so STOP is entered with a fresh tick count
            ct1 <= ct1 + 3'd1;
            if (ct1 == 3'd7) begin
              rsr <= {bitval, rsr[7:1]};
              ct2 <= ct2 + 4'd1;
              if (ct2 == 4'd7) begin
                state <= STOP;
              end
            end
          end
          STOP: begin
            ct1 <= ct1 + 3'd1;
            if (ct1 == 3'd7) begin
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end

      // A host read in the load cycle frees the register, so the new frame lands and oe clears.
      if (load) begin
        if (!rdrf || clrrdrf) begin
          rdr  <= rsr;
          rdrf <= 1'b1;
          fe   <= ~bitval;
          if (clrrdrf) begin
            oe <= 1'b0;
          end
        end else begin
          oe <= 1'b1;
        end
      end else if (clrrdrf) begin
        rdrf <= 1'b0;
        oe   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: table-driven and randomized frame checks of uart_rx against a frame-level flag model.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rstb = 1'b1;
  logic       bclkx8 = 1'b0;
  logic       rxd = 1'b1;
  logic       clrrdrf = 1'b1;
  logic [7:0] rdr;
  logic       rdrf;
  logic       oe;
  logic       fe;

  uart_rx dut (
    .clk    (clk),
    .rstb   (rstb),
    .bclkx8 (bclkx8),
    .rxd    (rxd),
    .clrrdrf(clrrdrf),
    .rdr    (rdr),
    .rdrf   (rdrf),
    .oe     (oe),
    .fe     (fe)
  );

  always #5 clk = ~clk;

  // Baud tick source: one high cycle in four; tickCount marks each rising bclkx8, stuckHigh freezes it at 1.
  logic stuckHigh = 1'b0;
  int   phase = 0;
  int   tickCount = 0;

  always @(posedge clk) begin
    #1;
    if (stuckHigh) begin
      bclkx8 = 1'b1;
    end else begin
      phase  = (phase + 1) % 4;
      bclkx8 = (phase == 0);
      if (phase == 0) tickCount++;
    end
  end

  int compared = 0;
  int mismatched = 0;

  logic [7:0] mRdr = 8'h00;
  logic       mRdrf = 1'b0;
  logic       mOe = 1'b0;
  logic       mFe = 1'b0;

  logic [7:0] preRdr, postRdr;
  logic       preRdrf, preOe, preFe, postRdrf, postOe, postFe;

  typedef struct {
    logic [7:0] data;
    logic       stopBit;
    logic       clrBefore;
    logic       clrAtLoad;
    logic [7:0] expRdr;
    logic       expRdrf;
    logic       expOe;
    logic       expFe;
  } vec_t;

  vec_t vecs[8];

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic waitTick();
    @(tickCount);
  endtask

  task automatic pulseClr();
    @(posedge clk);
    #1 clrrdrf = 1'b1;
    @(posedge clk);
    #1 clrrdrf = 1'b0;
    mRdrf = 1'b0;
    mOe   = 1'b0;
  endtask

  // Receiver-visible outcome of one complete frame, stated at the frame level.
  task automatic modelFrame(input logic [7:0] data, input logic stopBit, input logic clr);
    if (!mRdrf || clr) begin
      mRdr  = data;
      mRdrf = 1'b1;
      mFe   = ~stopBit;
      if (clr) mOe = 1'b0;
    end else begin
      mOe = 1'b1;
    end
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, " rdr"}, rdr, mRdr);
    checkOutput({tag, " rdrf"}, {7'd0, rdrf}, {7'd0, mRdrf});
    checkOutput({tag, " oe"}, {7'd0, oe}, {7'd0, mOe});
    checkOutput({tag, " fe"}, {7'd0, fe}, {7'd0, mFe});
  endtask

  // Drives one frame bit-aligned to ticks; snapshots outputs in the final stop tick cycle and just after it.
  task automatic sendFrame(input logic [7:0] data, input logic stopBit, input logic clrAtLoad,
                           input int glitchBit, input int stallCycles);
    waitTick();
    rxd = 1'b0;
    repeat (8) waitTick();
    for (int i = 0; i < 8; i++) begin
      rxd = data[i];
      if (i == 3 && stallCycles > 0) begin
        stuckHigh = 1'b1;
        repeat (stallCycles) @(negedge clk);
        stuckHigh = 1'b0;
      end
      repeat (4) waitTick();
      if (i == glitchBit) begin
        @(posedge clk);
        @(posedge clk);
        #1 rxd = ~data[i];
        @(posedge clk);
        #1 rxd = data[i];
      end
      repeat (4) waitTick();
    end
    rxd = stopBit;
    repeat (5) waitTick();
    if (clrAtLoad) clrrdrf = 1'b1;
    @(negedge clk);
    preRdr  = rdr;
    preRdrf = rdrf;
    preOe   = oe;
    preFe   = fe;
    @(posedge clk);
    #1;
    clrrdrf  = 1'b0;
    postRdr  = rdr;
    postRdrf = rdrf;
    postOe   = oe;
    postFe   = fe;
    repeat (3) waitTick();
    rxd = 1'b1;
    repeat (6) waitTick();
  endtask

  task automatic checkPre(input string tag);
    checkOutput({tag, " pre rdr"}, preRdr, mRdr);
    checkOutput({tag, " pre rdrf"}, {7'd0, preRdrf}, {7'd0, mRdrf});
    checkOutput({tag, " pre oe"}, {7'd0, preOe}, {7'd0, mOe});
    checkOutput({tag, " pre fe"}, {7'd0, preFe}, {7'd0, mFe});
  endtask

  task automatic checkPost(input string tag, input logic [7:0] eRdr, input logic eRdrf,
                           input logic eOe, input logic eFe);
    checkOutput({tag, " rdr"}, postRdr, eRdr);
    checkOutput({tag, " rdrf"}, {7'd0, postRdrf}, {7'd0, eRdrf});
    checkOutput({tag, " oe"}, {7'd0, postOe}, {7'd0, eOe});
    checkOutput({tag, " fe"}, {7'd0, postFe}, {7'd0, eFe});
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    if (v.clrBefore) begin
      pulseClr();
      checkOutput({tag, " clr rdrf"}, {7'd0, rdrf}, 8'd0);
      checkOutput({tag, " clr oe"}, {7'd0, oe}, 8'd0);
    end
    sendFrame(v.data, v.stopBit, v.clrAtLoad, -1, 0);
    checkPre(tag);
    checkPost(tag, v.expRdr, v.expRdrf, v.expOe, v.expFe);
    modelFrame(v.data, v.stopBit, v.clrAtLoad);
  endtask

  initial begin
    #800000;
    compared++;
    mismatched++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    logic [7:0] d;
    logic       s;
    logic       c;
    logic [7:0] gExp;

    vecs[0] = '{8'h55, 1'b1, 1'b0, 1'b0, 8'h55, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'hA3, 1'b0, 1'b1, 1'b0, 8'hA3, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{8'h11, 1'b1, 1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{8'h22, 1'b1, 1'b0, 1'b0, 8'h11, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{8'h33, 1'b1, 1'b1, 1'b0, 8'h33, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{8'h44, 1'b0, 1'b0, 1'b0, 8'h33, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{8'hC4, 1'b1, 1'b0, 1'b1, 8'hC4, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{8'h99, 1'b0, 1'b0, 1'b0, 8'hC4, 1'b1, 1'b1, 1'b0};

    $display("[TB] reset with clrrdrf held high");
    repeat (4) @(posedge clk);
    @(negedge clk);
    checkModel("reset");
    @(posedge clk);
    #1;
    rstb    = 1'b0;
    clrrdrf = 1'b0;
    repeat (3) waitTick();

    $display("[TB] directed frame table");
    for (int i = 0; i < 8; i++) applyStimulus(vecs[i], i);

    $display("[TB] short start glitch then 0x7E");
    pulseClr();
    waitTick();
    rxd = 1'b0;
    repeat (2) waitTick();
    rxd = 1'b1;
    repeat (12) waitTick();
    checkOutput("glitch rdrf", {7'd0, rdrf}, 8'd0);
    sendFrame(8'h7E, 1'b1, 1'b0, -1, 0);
    modelFrame(8'h7E, 1'b1, 1'b0);
    checkPost("rx7E", 8'h7E, 1'b1, 1'b0, 1'b0);

    $display("[TB] frame with bclkx8 stuck high mid-frame");
    pulseClr();
    sendFrame(8'h5A, 1'b1, 1'b0, -1, 300);
    checkPre("stall");
    modelFrame(8'h5A, 1'b1, 1'b0);
    checkPost("stall", 8'h5A, 1'b1, 1'b0, 1'b0);

    $display("[TB] randomized frames");
    for (int n = 0; n < 24; n++) begin
      d = 8'($urandom);
      s = ($urandom % 5) != 0;
      c = ($urandom % 4) == 0;
      if (($urandom % 3) == 0) pulseClr();
      sendFrame(d, s, c, -1, 0);
      checkPre($sformatf("rnd%0d", n));
      modelFrame(d, s, c);
      checkPost($sformatf("rnd%0d", n), mRdr, mRdrf, mOe, mFe);
    end

    $display("[TB] reset during bit 4 of 0xFF");
    pulseClr();
    sendFrame(8'h3C, 1'b0, 1'b0, -1, 0);
    modelFrame(8'h3C, 1'b0, 1'b0);
    sendFrame(8'h81, 1'b1, 1'b0, -1, 0);
    modelFrame(8'h81, 1'b1, 1'b0);
    checkModel("prereset");
    waitTick();
    rxd = 1'b0;
    repeat (8) waitTick();
    rxd = 1'b1;
    repeat (35) waitTick();
    @(posedge clk);
    #1;
    rstb    = 1'b1;
    clrrdrf = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mRdr = 8'h00; mRdrf = 1'b0; mOe = 1'b0; mFe = 1'b0;
    checkModel("midreset");
    @(posedge clk);
    #1;
    rstb    = 1'b0;
    clrrdrf = 1'b0;
    repeat (50) waitTick();
    sendFrame(8'h0F, 1'b1, 1'b0, -1, 0);
    checkPre("after reset");
    modelFrame(8'h0F, 1'b1, 1'b0);
    checkPost("after reset", 8'h0F, 1'b1, 1'b0, 1'b0);

    $display("[TB] one-clk glitch at the bit 0 decision tick");
`ifdef UART_RX_MAJORITY_EN
    gExp = 8'h0F;
`else
    gExp = 8'h0E;
`endif
    pulseClr();
    sendFrame(8'h0F, 1'b1, 1'b0, 0, 0);
    modelFrame(gExp, 1'b1, 1'b0);
    checkPost("bit glitch", gExp, 1'b1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
